// File: rtl/fifo_rd_fwft.sv
// First-word-fall-through output stage for the read side of the async FIFO.
// Pops words from the FIFO memory and presents them through a 2-entry head/skid buffer.
module fifo_rd_fwft #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_rd_clk,
    input  logic                  i_rd_rst,
    input  logic                  i_empty,
    output logic                  o_rd_en,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [1:0]            o_count
);

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    buf_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  inflight_q, inflight_d;
    logic                  pop;
    logic                  rd_en;
    logic [2:0]            occupancy;

    assign pop = (state_q != BUF_EMPTY) && i_ready;

    // Words that will be held after this edge, counting the one still in flight from memory.
    assign occupancy = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en     = !i_empty && (occupancy < 3'd2);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        head_d     = head_q;
        skid_d     = skid_q;
        inflight_d = rd_en;
        unique case (state_q)
            BUF_EMPTY: begin
                if (inflight_q) begin
                    head_d  = i_mem_data;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (pop && inflight_q) begin
                    head_d = i_mem_data;
                end else if (pop) begin
                    state_d = BUF_EMPTY;
                end else if (inflight_q) begin
                    skid_d  = i_mem_data;
                    state_d = BUF_TWO;
                end
            end
            BUF_TWO: begin
                // An arrival is impossible here: rd_en stays low while the buffer is full.
                if (pop) begin
                    head_d  = skid_q;
                    state_d = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_rd_clk or negedge i_rd_rst) begin
        if (!i_rd_rst) begin
            state_q    <= BUF_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            inflight_q <= inflight_d;
        end
    end

    assign o_rd_en = rd_en;
    assign o_data  = head_q;
    assign o_valid = (state_q != BUF_EMPTY);
    assign o_count = state_q;

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Self-checking bench for fifo_rd_fwft: upstream FIFO model, in-order scoreboard, occupancy model.
module tb_fifo_rd_fwft;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_empty = 1'b1;
    logic          i_ready = 1'b1;
    logic [DW-1:0] i_mem_data = '0;
    logic          o_rd_en;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic [1:0]    o_count;

    fifo_rd_fwft #(.DATA_WIDTH(DW)) dut (
        .i_rd_clk   (clk),
        .i_rd_rst   (rst_n),
        .i_empty    (i_empty),
        .o_rd_en    (o_rd_en),
        .i_mem_data (i_mem_data),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_count    (o_count)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] src_q[$];   // words sitting in the upstream FIFO
    logic [DW-1:0] exp_q[$];   // every word written, in the order it must come out

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        src_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic next_slot(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Upstream model: a sampled pop removes the head of src_q and shows it on the memory port next cycle.
    bit pop_s;
    initial begin
        forever begin
            @(negedge clk);
            pop_s = rst_n && o_rd_en;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                i_empty = 1'b1;
            end else begin
                if (pop_s && src_q.size() > 0) i_mem_data = src_q.pop_front();
                else                           i_mem_data = DW'($urandom);
                i_empty = (src_q.size() == 0);
            end
        end
    end

    // Monitor: occupancy bookkeeping plus in-order data comparison on every accepted word.
    int            buf_m;
    bit            infl_m, pop_p, cons_p, hold_p;
    logic [DW-1:0] data_p;
    initial begin
        buf_m = 0; infl_m = 0; pop_p = 0; cons_p = 0; hold_p = 0; data_p = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                buf_m = 0; infl_m = 0; pop_p = 0; cons_p = 0; hold_p = 0;
            end else begin
                buf_m  = buf_m + int'(infl_m) - int'(cons_p);
                infl_m = pop_p;
                check("count_model", 32'(o_count), 32'(buf_m));
                check("valid_model", 32'(o_valid), 32'(buf_m != 0));
                check("occupancy_bound", 32'((buf_m + int'(infl_m)) <= 2), 32'd1);
                check("rd_en_while_empty", 32'(o_rd_en & i_empty), 32'd0);
                if (hold_p) check("backpressure_hold", {23'd0, o_valid, o_data}, {23'd0, 1'b1, data_p});
                if (o_valid && i_ready) begin
                    check("scoreboard_has_word", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) check("data_order", 32'(o_data), 32'(exp_q.pop_front()));
                end
                pop_p  = o_rd_en;
                cons_p = o_valid && i_ready;
                hold_p = o_valid && !i_ready;
                data_p = o_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int rd_cnt, rd_first, rd_last, cs_cnt, cs_first, cs_last, k;

    initial begin
        // Reset held, then released with the FIFO still empty.
        next_slot(3);
        @(negedge clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_rd_en", 32'(o_rd_en), 32'd0);
        next_slot(1);
        rst_n = 1'b1;
        next_slot(3);
        @(negedge clk);
        check("idle_valid", 32'(o_valid), 32'd0);
        check("idle_count", 32'(o_count), 32'd0);
        check("idle_rd_en", 32'(o_rd_en), 32'd0);

        // Single word with the consumer stalled.
        next_slot(1);
        i_ready = 1'b0;
        push_word(8'hA5);
        rd_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_rd_en) rd_cnt++;
        end
        check("single_rd_en_pulses", 32'(rd_cnt), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("single_hold", {22'd0, o_count, o_valid, o_data}, {22'd0, 2'd1, 1'b1, 8'hA5});
        end
        next_slot(1);
        i_ready = 1'b1;
        next_slot(3);

        // Streaming: 16 words at one per cycle.
        for (int i = 0; i < 16; i++) push_word(8'(i));
        rd_cnt = 0; cs_cnt = 0; rd_first = -1; rd_last = -1; cs_first = -1; cs_last = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_rd_en) begin
                if (rd_first < 0) rd_first = i;
                rd_last = i;
                rd_cnt++;
            end
            if (o_valid && i_ready) begin
                if (cs_first < 0) cs_first = i;
                cs_last = i;
                cs_cnt++;
            end
        end
        check("stream_rd_en_count", 32'(rd_cnt), 32'd16);
        check("stream_rd_en_span", 32'(rd_last - rd_first), 32'd15);
        check("stream_word_count", 32'(cs_cnt), 32'd16);
        check("stream_word_span", 32'(cs_last - cs_first), 32'd15);

        // Backpressure: stall four cycles with words pending.
        next_slot(1);
        for (int i = 8'h10; i <= 8'h17; i++) push_word(8'(i));
        next_slot(3);
        i_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("bp_full_count", 32'(o_count), 32'd2);
        check("bp_full_rd_en", 32'(o_rd_en), 32'd0);
        check("bp_full_valid", 32'(o_valid), 32'd1);
        next_slot(1);
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_resume_rate", 32'(o_valid && i_ready), 32'd1);
        end
        next_slot(12);

        // Drain to empty after three words.
        for (int i = 0; i < 3; i++) push_word(8'(8'h30 + i));
        next_slot(10);
        @(negedge clk);
        check("drain_valid", 32'(o_valid), 32'd0);
        check("drain_count", 32'(o_count), 32'd0);
        check("drain_rd_en", 32'(o_rd_en), 32'd0);
        check("drain_all_delivered", 32'(exp_q.size()), 32'd0);

        // Reset while the buffer is full and a new pop is being requested.
        next_slot(1);
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'(8'h40 + i));
        k = 0;
        while (o_count != 2'd2 && k < 20) begin
            next_slot(1);
            k++;
        end
        check("midrst_fill", 32'(o_count), 32'd2);
        i_ready = 1'b1;
        #1;
        check("midrst_rd_en_before", 32'(o_rd_en), 32'd1);
        rst_n = 1'b0;
        i_empty = 1'b1;
        src_q.delete();
        exp_q.delete();
        #1;
        check("midrst_async_clear", {21'd0, o_rd_en, o_count, o_valid, o_data}, 32'd0);
        next_slot(2);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_no_stale", 32'(o_valid), 32'd0);
        end

        // Randomized traffic with random consumer stalls.
        next_slot(1);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) push_word(DW'($urandom));
            i_ready = ($urandom_range(0, 3) != 0);
            next_slot(1);
        end
        i_ready = 1'b1;
        next_slot(30);
        check("random_all_delivered", 32'(exp_q.size()), 32'd0);
        check("random_final_count", 32'(o_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
